prt_dptx_sr_sched: RTL and testbench
====================================

Name: prt_dptx_sr_sched

Overview:
- Scrambler-reset scheduler between the TX link framer and the TX scrambler.
- Counts qualifying marker symbols in the link symbol stream: BS in SST, MTPH in MST.
- Replaces the first marker after enable with SR, then every P_SR_INTERVAL-th marker.
- Drives the scrambler enable, so the scrambler LFSR at both link ends is re-seeded at a deterministic cadence.

Parameters:
- P_SIM, 0, simulation mode; when 1, the effective interval is forced to 8.
- P_SPL, 2, symbols per lane (sublanes per clock), 1..4.
- P_SR_INTERVAL, 512, markers per SR; the SR itself counts as marker 1. Legal values 2..1024.

Ports:
- CLK_IN  in  1  link clock.
- RST_IN  in  1  reset, asynchronous, active-low.
- CTL_EN_IN  in  1  scheduler enable (low during training patterns).
- CTL_MST_IN  in  1  0 = SST (marker is TX_LNK_SYM_BS), 1 = MST (marker is TX_LNK_SYM_MTPH).
- SNK_SYM_IN  in  P_SPL*P_SYM_W  link symbol per sublane; sublane 0 in the LSBs, time-earliest.
- SNK_DAT_IN  in  P_SPL*8  data byte per sublane.
- SRC_SYM_OUT  out  P_SPL*P_SYM_W  symbols to the scrambler.
- SRC_DAT_OUT  out  P_SPL*8  data to the scrambler.
- CTL_SCRM_EN_OUT  out  1  scrambler enable.
- STA_LOCK_OUT  out  1  high in state RUN.
- STA_SR_CNT_OUT  out  16  number of SRs inserted; wraps at 65535 -> 0.

Behaviour:
- Reset (RST_IN low, asynchronous):
  - state IDLE, marker counter 0.
  - SRC_SYM_OUT = TX_LNK_SYM_NOP on all sublanes, SRC_DAT_OUT = 0.
  - CTL_SCRM_EN_OUT, STA_LOCK_OUT = 0; STA_SR_CNT_OUT = 0.
- Datapath: fixed latency of 1 clock, all outputs registered, stream accepted every cycle (no backpressure).
  - Non-replaced symbols pass through with sym and dat unchanged.
  - A replaced symbol becomes TX_LNK_SYM_SR; its dat is passed unchanged.
- Input sampling: CTL_EN_IN and CTL_MST_IN are sampled every clock. The state used for cycle t data is the state registered at the start of cycle t.
- States:
  - IDLE:
    - pass-through, counter held at 0, CTL_SCRM_EN_OUT = 0.
    - CTL_EN_IN = 1 -> ARM.
  - ARM:
    - the first marker, in the lowest sublane that carries one, is replaced with SR; counter <= 1; state -> RUN.
    - any further markers in the same cycle are counted as in RUN.
    - CTL_SCRM_EN_OUT = 1 from the first clock after entering ARM.
  - RUN:
    - sublanes are processed in order 0..P_SPL-1.
    - each marker: if counter == interval, replace with SR and set counter = 1; otherwise pass it and increment the counter.
    - counter width is clog2(P_SR_INTERVAL)+1; it never exceeds the interval.
- Multiple markers per cycle: all are handled in sublane order within one clock. Each replacement increments STA_SR_CNT_OUT, at most P_SPL per clock.
- CTL_EN_IN falls in ARM or RUN:
  - next state IDLE, counter cleared.
  - CTL_SCRM_EN_OUT deasserts on the same edge.
  - data in flight still passes with 1-clock latency.
- CTL_MST_IN changes while ARM or RUN: next state ARM, counter cleared. The next marker of the new type becomes SR.
- An upstream TX_LNK_SYM_SR already present on the input is passed through and resets the counter to 1, as if inserted. STA_SR_CNT_OUT is not incremented for it.
- Markers of the other mode's type (BS in MST, MTPH in SST) are passed through and not counted.

Decomposition:
- prt_dp_pkg:
  - add enum value TX_LNK_SYM_MTPH to prt_dp_tx_lnk_sym.
  - add constant P_SYM_W, the symbol width.
  - require TX_LNK_SYM_NOP = 0.
- Local typedef for the state enum (IDLE, ARM, RUN) stays in the module.
- No sub-module: the per-sublane replace/count chain is a combinational loop over P_SPL inside one always_comb, followed by a single output register stage.

Test Plan:
- SST, P_SR_INTERVAL=8, enable, one BS on sublane 0 every 10 cycles:
  - output BS #1, #9, #17 are SR; all other BS pass.
  - STA_SR_CNT_OUT = 3 after 17 BS; STA_LOCK_OUT rises 1 clock after BS #1 is seen.
- P_SPL=2, BS on both sublanes in the same cycle with counter at 7 (interval 8): sublane 0 passes BS (counter -> 8), sublane 1 becomes SR, counter = 1.
- Disable mid-run after BS #5: next edge state IDLE, CTL_SCRM_EN_OUT = 0. Re-enable: the first BS is SR and the count restarts.
- MST switch during RUN (CTL_MST_IN 0 -> 1):
  - BS symbols are thereafter passed untouched.
  - the first MTPH is SR, then every 8th MTPH.
- Assert RST_IN low asynchronously between clock edges mid-stream:
  - outputs go to NOP/0, status to 0, without waiting for a clock edge.
  - after release with EN high, the first BS is SR.
- Upstream SR injected when counter = 4: SR passes, and the 8th marker after that SR (7 BS later) is replaced. STA_SR_CNT_OUT is unchanged by the injected SR.

Source files
------------

// File: rtl/prt_dp_pkg.sv
// Shared DisplayPort TX definitions: link symbol encoding used between framer,
// scheduler and scrambler.
package prt_dp_pkg;

    localparam int unsigned P_SYM_W = 4;

    // NOP must stay at zero so that a cleared symbol bus reads as idle.
    typedef enum logic [P_SYM_W-1:0] {
        TX_LNK_SYM_NOP  = 4'd0,
        TX_LNK_SYM_DAT  = 4'd1,
        TX_LNK_SYM_BS   = 4'd2,
        TX_LNK_SYM_BE   = 4'd3,
        TX_LNK_SYM_SR   = 4'd4,
        TX_LNK_SYM_FS   = 4'd5,
        TX_LNK_SYM_FE   = 4'd6,
        TX_LNK_SYM_BF   = 4'd7,
        TX_LNK_SYM_MTPH = 4'd8
    } prt_dp_tx_lnk_sym;

endpackage

// File: rtl/prt_dptx_sr_sched.sv
// Scrambler-reset scheduler: replaces every interval-th BS (SST) or MTPH (MST)
// marker with SR and drives the scrambler enable, one clock of latency.
module prt_dptx_sr_sched
    import prt_dp_pkg::*;
#(
    parameter int unsigned P_SIM         = 0,
    parameter int unsigned P_SPL         = 2,
    parameter int unsigned P_SR_INTERVAL = 512
) (
    input  logic                       CLK_IN,
    input  logic                       RST_IN,
    input  logic                       CTL_EN_IN,
    input  logic                       CTL_MST_IN,
    input  logic [P_SPL*P_SYM_W-1:0]   SNK_SYM_IN,
    input  logic [P_SPL*8-1:0]         SNK_DAT_IN,
    output logic [P_SPL*P_SYM_W-1:0]   SRC_SYM_OUT,
    output logic [P_SPL*8-1:0]         SRC_DAT_OUT,
    output logic                       CTL_SCRM_EN_OUT,
    output logic                       STA_LOCK_OUT,
    output logic [15:0]                STA_SR_CNT_OUT
);

    localparam int unsigned INTERVAL = (P_SIM != 0) ? 8 : P_SR_INTERVAL;
    // Sized from the effective interval so simulation mode always fits 8.
    localparam int unsigned CNT_W    = $clog2(INTERVAL) + 1;
    localparam int unsigned SRN_W    = $clog2(P_SPL + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           cnt_nxt;
    logic [CNT_W-1:0]           cnt_run;
    logic                       mst_q;
    logic                       armed;
    logic [SRN_W-1:0]           srs;
    logic [P_SYM_W-1:0]         sym_i;
    logic [P_SPL*P_SYM_W-1:0]   sym_nxt;
    logic                       scrm_en_nxt;
    logic                       lock_nxt;
    logic [15:0]                sr_cnt_nxt;
    prt_dp_tx_lnk_sym           marker;

    assign marker = mst_q ? TX_LNK_SYM_MTPH : TX_LNK_SYM_BS;

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state           <= IDLE;
            cnt             <= '0;
            mst_q           <= 1'b0;
            SRC_SYM_OUT     <= '0;
            SRC_DAT_OUT     <= '0;
            CTL_SCRM_EN_OUT <= 1'b0;
            STA_LOCK_OUT    <= 1'b0;
            STA_SR_CNT_OUT  <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            mst_q           <= CTL_MST_IN;
            SRC_SYM_OUT     <= sym_nxt;
            SRC_DAT_OUT     <= SNK_DAT_IN;
            CTL_SCRM_EN_OUT <= scrm_en_nxt;
            STA_LOCK_OUT    <= lock_nxt;
            STA_SR_CNT_OUT  <= sr_cnt_nxt;
        end
    end

    // Sublane chain: the running count ripples from sublane 0 upward so several
    // markers in one beat are resolved in time order within a single clock.
    always_comb begin
        sym_nxt = SNK_SYM_IN;
        sym_i   = '0;
        cnt_run = cnt;
        armed   = (state == ARM);
        srs     = '0;
        if (state != IDLE) begin
            for (int unsigned i = 0; i < P_SPL; i++) begin
                sym_i = SNK_SYM_IN[i*P_SYM_W +: P_SYM_W];
                if (sym_i == TX_LNK_SYM_SR) begin
                    cnt_run = CNT_W'(1);
                    armed   = 1'b0;
                end else if (sym_i == marker) begin
                    if (armed || (cnt_run == CNT_W'(INTERVAL))) begin
                        sym_nxt[i*P_SYM_W +: P_SYM_W] = TX_LNK_SYM_SR;
                        cnt_run = CNT_W'(1);
                        armed   = 1'b0;
                        srs     = srs + SRN_W'(1);
                    end else begin
                        cnt_run = cnt_run + CNT_W'(1);
                    end
                end
            end
        end

        state_nxt = state;
        cnt_nxt   = cnt_run;
        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                state_nxt = CTL_EN_IN ? ARM : IDLE;
            end
            default: begin
                if (!CTL_EN_IN) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (CTL_MST_IN != mst_q) begin
                    state_nxt = ARM;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = armed ? ARM : RUN;
                end
            end
        endcase
    end

    always_comb begin
        scrm_en_nxt = (state_nxt != IDLE);
        lock_nxt    = (state_nxt == RUN);
        sr_cnt_nxt  = STA_SR_CNT_OUT + 16'(srs);
    end

endmodule

// File: tb/tb_prt_dptx_sr_sched.sv
// Directed bench for prt_dptx_sr_sched with interval 8 and two sublanes.
module tb_prt_dptx_sr_sched;
    import prt_dp_pkg::*;

    localparam int unsigned SPL = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     en;
    logic                     mst;
    logic [SPL*P_SYM_W-1:0]   snk_sym;
    logic [SPL*8-1:0]         snk_dat;
    logic [SPL*P_SYM_W-1:0]   src_sym;
    logic [SPL*8-1:0]         src_dat;
    logic                     scrm_en;
    logic                     lock;
    logic [15:0]              sr_cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    prt_dptx_sr_sched #(
        .P_SIM         (0),
        .P_SPL         (SPL),
        .P_SR_INTERVAL (8)
    ) dut (
        .CLK_IN          (clk),
        .RST_IN          (rst_n),
        .CTL_EN_IN       (en),
        .CTL_MST_IN      (mst),
        .SNK_SYM_IN      (snk_sym),
        .SNK_DAT_IN      (snk_dat),
        .SRC_SYM_OUT     (src_sym),
        .SRC_DAT_OUT     (src_dat),
        .CTL_SCRM_EN_OUT (scrm_en),
        .STA_LOCK_OUT    (lock),
        .STA_SR_CNT_OUT  (sr_cnt)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [P_SYM_W-1:0] s0, input logic [P_SYM_W-1:0] s1,
                        input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clk);
        snk_sym = {s1, s0};
        snk_dat = {d1, d0};
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sym(input string tag, input int unsigned e0, input int unsigned e1);
        chk({tag, "_s0"}, int'(src_sym[P_SYM_W-1:0]), e0);
        chk({tag, "_s1"}, int'(src_sym[2*P_SYM_W-1:P_SYM_W]), e1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        mst     = 1'b0;
        snk_sym = {TX_LNK_SYM_BS, TX_LNK_SYM_BS};
        snk_dat = 16'hA55A;
        #12;
        chk("rst_sym", int'(src_sym), 0);
        chk("rst_dat", int'(src_dat), 0);
        chk("rst_scrm", int'(scrm_en), 0);
        chk("rst_lock", int'(lock), 0);
        chk("rst_srcnt", int'(sr_cnt), 0);

        @(negedge clk);
        rst_n   = 1'b1;
        en      = 1'b1;
        snk_sym = '0;
        snk_dat = '0;
        @(posedge clk);
        #1;
        chk("arm_scrm", int'(scrm_en), 1);
        chk("arm_lock", int'(lock), 0);

        // SST: markers 1, 9, 17 become SR
        for (int k = 1; k <= 17; k++) begin
            step(TX_LNK_SYM_BS, TX_LNK_SYM_NOP, 8'(k), 8'h00);
            chk_sym("sst", (k % 8 == 1) ? TX_LNK_SYM_SR : TX_LNK_SYM_BS, TX_LNK_SYM_NOP);
            chk("sst_dat", int'(src_dat[7:0]), k);
            if (k == 1) chk("sst_lock", int'(lock), 1);
            step(TX_LNK_SYM_NOP, TX_LNK_SYM_NOP, 8'h00, 8'h00);
        end
        chk("sst_srcnt", int'(sr_cnt), 3);

        // Two markers in one beat with count at 7
        for (int j = 0; j < 6; j++) begin
            step(TX_LNK_SYM_BS, TX_LNK_SYM_NOP, 8'h00, 8'h00);
            chk_sym("pre_dual", TX_LNK_SYM_BS, TX_LNK_SYM_NOP);
        end
        step(TX_LNK_SYM_BS, TX_LNK_SYM_BS, 8'h11, 8'h22);
        chk_sym("dual", TX_LNK_SYM_BS, TX_LNK_SYM_SR);
        chk("dual_dat", int'(src_dat), 16'h2211);
        chk("dual_srcnt", int'(sr_cnt), 4);

        // Disable mid-run, then re-enable
        for (int j = 0; j < 4; j++) begin
            step(TX_LNK_SYM_BS, TX_LNK_SYM_NOP, 8'h00, 8'h00);
            chk_sym("pre_dis", TX_LNK_SYM_BS, TX_LNK_SYM_NOP);
        end
        en = 1'b0;
        step(TX_LNK_SYM_NOP, TX_LNK_SYM_NOP, 8'h00, 8'h00);
        chk("dis_scrm", int'(scrm_en), 0);
        chk("dis_lock", int'(lock), 0);
        step(TX_LNK_SYM_BS, TX_LNK_SYM_NOP, 8'h33, 8'h00);
        chk_sym("idle_pass", TX_LNK_SYM_BS, TX_LNK_SYM_NOP);
        en = 1'b1;
        step(TX_LNK_SYM_NOP, TX_LNK_SYM_NOP, 8'h00, 8'h00);
        chk("reen_scrm", int'(scrm_en), 1);
        for (int j = 0; j < 9; j++) begin
            step(TX_LNK_SYM_BS, TX_LNK_SYM_NOP, 8'h00, 8'h00);
            chk_sym("reen", (j == 0 || j == 8) ? TX_LNK_SYM_SR : TX_LNK_SYM_BS, TX_LNK_SYM_NOP);
        end
        chk("reen_srcnt", int'(sr_cnt), 6);

        // Switch to MST: BS becomes transparent, MTPH is the marker
        mst = 1'b1;
        step(TX_LNK_SYM_NOP, TX_LNK_SYM_NOP, 8'h00, 8'h00);
        chk("mst_lock", int'(lock), 0);
        chk("mst_scrm", int'(scrm_en), 1);
        for (int j = 1; j <= 9; j++) begin
            step(TX_LNK_SYM_MTPH, TX_LNK_SYM_BS, 8'h00, 8'h00);
            chk_sym("mst", (j == 1 || j == 9) ? TX_LNK_SYM_SR : TX_LNK_SYM_MTPH, TX_LNK_SYM_BS);
        end
        chk("mst_lock_run", int'(lock), 1);
        chk("mst_srcnt", int'(sr_cnt), 8);

        // Upstream SR with count at 4 restarts the interval
        for (int j = 0; j < 3; j++) begin
            step(TX_LNK_SYM_MTPH, TX_LNK_SYM_NOP, 8'h00, 8'h00);
            chk_sym("pre_up", TX_LNK_SYM_MTPH, TX_LNK_SYM_NOP);
        end
        step(TX_LNK_SYM_SR, TX_LNK_SYM_NOP, 8'h5A, 8'h00);
        chk_sym("up_sr", TX_LNK_SYM_SR, TX_LNK_SYM_NOP);
        chk("up_dat", int'(src_dat[7:0]), 8'h5A);
        chk("up_srcnt", int'(sr_cnt), 8);
        for (int j = 0; j < 8; j++) begin
            step(TX_LNK_SYM_MTPH, TX_LNK_SYM_NOP, 8'h00, 8'h00);
            chk_sym("post_up", (j == 7) ? TX_LNK_SYM_SR : TX_LNK_SYM_MTPH, TX_LNK_SYM_NOP);
        end
        chk("post_up_srcnt", int'(sr_cnt), 9);

        // Asynchronous reset between edges
        step(TX_LNK_SYM_MTPH, TX_LNK_SYM_NOP, 8'h77, 8'h00);
        chk_sym("pre_arst", TX_LNK_SYM_MTPH, TX_LNK_SYM_NOP);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sym", int'(src_sym), 0);
        chk("arst_dat", int'(src_dat), 0);
        chk("arst_scrm", int'(scrm_en), 0);
        chk("arst_lock", int'(lock), 0);
        chk("arst_srcnt", int'(sr_cnt), 0);
        mst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        rst_n   = 1'b1;
        snk_sym = '0;
        snk_dat = '0;
        @(posedge clk);
        #1;
        chk("rel_scrm", int'(scrm_en), 1);
        step(TX_LNK_SYM_BS, TX_LNK_SYM_NOP, 8'h00, 8'h00);
        chk_sym("rel_first", TX_LNK_SYM_SR, TX_LNK_SYM_NOP);
        chk("rel_srcnt", int'(sr_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
